// File: rtl/seg7_pkg.sv
// Seven-segment code table and decode helper, shared with the display driver.
// Combinational helpers only; no latency.
// No flow control; pure constants and functions.
package seg7_pkg;

  localparam int DIGITS = 4;

  // abcdefg, active-low; entry i is the pattern that shows hex digit i
  localparam logic [15:0][6:0] SSEG_CODE = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } hex_dec_t;

  // Exact 7-bit match against the table; valid=0 when nothing matches
  function automatic hex_dec_t sseg_to_hex(input logic [6:0] pat);
    hex_dec_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (pat == SSEG_CODE[i]) begin
        r.valid = 1'b1;
        r.value = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sseg_scan_capture_if.sv
// Scanned display lines plus the rebuilt digit view.
// Wires only; no latency.
// No flow control; the scan is free-running and sampled continuously.
interface sseg_scan_capture_if;
  import seg7_pkg::*;

  logic [DIGITS-1:0] an_in;
  logic [7:0]        sseg_in;
  logic [3:0]        hex0;
  logic [3:0]        hex1;
  logic [3:0]        hex2;
  logic [3:0]        hex3;
  logic [DIGITS-1:0] dp_out;
  logic [DIGITS-1:0] seg_err;
  logic              frame_valid;
  logic              onehot_err;
  logic              scan_lost;

  // Display driver side: drives the scan lines, observes the readback
  modport master (
    output an_in, sseg_in,
    input  hex0, hex1, hex2, hex3, dp_out, seg_err, frame_valid, onehot_err, scan_lost
  );

  // Capture side: samples the scan lines, drives the readback
  modport slave (
    input  an_in, sseg_in,
    output hex0, hex1, hex2, hex3, dp_out, seg_err, frame_valid, onehot_err, scan_lost
  );

endinterface

// File: rtl/sseg_scan_capture_decode.sv
// Segment pattern to hex nibble lookup.
// Combinational, zero latency.
// No flow control.
module sseg_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic       valid_o,
  output logic [3:0] hex_o
);

  hex_dec_t dec;

  // Table lookup through the shared helper
  always_comb begin
    dec     = sseg_to_hex(pat_i);
    valid_o = dec.valid;
    hex_o   = dec.value;
  end

endmodule

// File: rtl/sseg_scan_capture.sv
// Rebuilds the four scanned hex digits/dps and flags bad patterns, bad enables, lost scan.
// Outputs update STABLE_CNT edges after a new an/sseg value first appears and holds.
// No backpressure: the scan is sampled every cycle; short dwells are silently ignored.
module sseg_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT     = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               reset,
  sseg_scan_capture_if.slave bus
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [11:0]             pins;
  logic [11:0]             samp_q;
  logic [CW-1:0]           stab_q, stab_d;
  logic                    captured_q, captured_d;
  logic [DIGITS-1:0][3:0]  hex_q, hex_d;
  logic [DIGITS-1:0]       dp_q, dp_d;
  logic [DIGITS-1:0]       err_q, err_d;
  logic [DIGITS-1:0]       seen_q, seen_d;
  logic                    fv_q, fv_d;
  logic                    oh_q, oh_d;
  logic [TW-1:0]           to_q, to_d;

  logic [DIGITS-1:0]       an_s;
  logic                    stable, cap, an_onehot, digit_cap, onehot_cap;
  logic [1:0]              idx;
  logic                    dec_vld;
  logic [3:0]              dec_hex;

  assign pins       = {bus.an_in, bus.sseg_in};
  assign an_s       = samp_q[11:8];
  assign stable     = (pins == samp_q);
  // The capture edge is the STABLE_CNT-th edge of an unchanged dwell; captured_q
  // keeps a long dwell from being captured more than once.
  assign cap        = stable && (stab_q == CW'(STABLE_CNT - 1)) && !captured_q;
  assign an_onehot  = (an_s != '0) && ((an_s & (an_s - 4'd1)) == '0);
  assign digit_cap  = cap && an_onehot;
  assign onehot_cap = cap && !an_onehot;

  // On a capture edge pins equal the sample, so decoding the sample is exact
  sseg_decode u_decode (
    .pat_i   (samp_q[6:0]),
    .valid_o (dec_vld),
    .hex_o   (dec_hex)
  );

  // Digit index of a one-hot enable
  always_comb begin
    idx = 2'd0;
    case (an_s)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // Next state: stability tracking, digit update, frame/timeout bookkeeping
  always_comb begin
    stab_d     = stab_q;
    captured_d = captured_q;
    hex_d      = hex_q;
    dp_d       = dp_q;
    err_d      = err_q;
    seen_d     = seen_q;
    fv_d       = 1'b0;
    oh_d       = 1'b0;
    to_d       = (to_q == TW'(TIMEOUT_CYCLES)) ? to_q : to_q + 1'b1;

    if (!stable) begin
      stab_d     = '0;
      captured_d = 1'b0;
    end else if (stab_q != CW'(STABLE_CNT)) begin
      stab_d = stab_q + 1'b1;
    end

    if (cap) captured_d = 1'b1;

    if (digit_cap) begin
      dp_d[idx] = samp_q[7];
      if (dec_vld) begin
        hex_d[idx] = dec_hex;
        err_d[idx] = 1'b0;
      end else begin
        err_d[idx] = 1'b1;
      end
      to_d   = '0;
      seen_d = seen_q | an_s;
      if (seen_d == 4'hF) begin
        fv_d   = 1'b1;
        seen_d = '0;
      end
    end else if (onehot_cap) begin
      oh_d = 1'b1;
    end
  end

  // State registers with asynchronous reset; reset discards any partial frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_q     <= '0;
      stab_q     <= '0;
      captured_q <= 1'b0;
      hex_q      <= '0;
      dp_q       <= '0;
      err_q      <= '0;
      seen_q     <= '0;
      fv_q       <= 1'b0;
      oh_q       <= 1'b0;
      to_q       <= '0;
    end else begin
      samp_q     <= pins;
      stab_q     <= stab_d;
      captured_q <= captured_d;
      hex_q      <= hex_d;
      dp_q       <= dp_d;
      err_q      <= err_d;
      seen_q     <= seen_d;
      fv_q       <= fv_d;
      oh_q       <= oh_d;
      to_q       <= to_d;
    end
  end

  assign bus.hex0        = hex_q[0];
  assign bus.hex1        = hex_q[1];
  assign bus.hex2        = hex_q[2];
  assign bus.hex3        = hex_q[3];
  assign bus.dp_out      = dp_q;
  assign bus.seg_err     = err_q;
  assign bus.frame_valid = fv_q;
  assign bus.onehot_err  = oh_q;
  assign bus.scan_lost   = (to_q == TW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed bench for the scan capture monitor.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// No flow control on the DUT; every wait is a fixed cycle count.
module tb_sseg_scan_capture;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;
  int   fv_cnt;
  int   oh_cnt;
  bit   saw1;

  sseg_scan_capture_if bus ();

  sseg_scan_capture #(.STABLE_CNT(2), .TIMEOUT_CYCLES(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample and record pulses/history
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.frame_valid) fv_cnt++;
    if (bus.onehot_err) oh_cnt++;
    if (bus.hex1 == 4'h1) saw1 = 1'b1;
  endtask

  task automatic hold(input logic [3:0] an, input logic [7:0] sg, input int n);
    bus.an_in   = an;
    bus.sseg_in = sg;
    repeat (n) step();
  endtask

  initial begin
    fv_cnt = 0;
    oh_cnt = 0;
    saw1   = 1'b0;
    reset  = 1'b1;
    bus.an_in   = 4'b0001;
    bus.sseg_in = 8'h86;
    repeat (2) step();

    // Reset state
    chk("rst_hex0", 32'(bus.hex0), 0);
    chk("rst_hex1", 32'(bus.hex1), 0);
    chk("rst_hex2", 32'(bus.hex2), 0);
    chk("rst_hex3", 32'(bus.hex3), 0);
    chk("rst_dp", 32'(bus.dp_out), 0);
    chk("rst_segerr", 32'(bus.seg_err), 0);
    chk("rst_fv", 32'(bus.frame_valid), 0);
    chk("rst_oh", 32'(bus.onehot_err), 0);
    chk("rst_lost", 32'(bus.scan_lost), 0);

    // Single digit: capture on the 3rd edge of the dwell, not earlier
    reset = 1'b0;
    step();
    step();
    chk("single_early_hex0", 32'(bus.hex0), 0);
    step();
    chk("single_hex0", 32'(bus.hex0), 3);
    chk("single_dp", 32'(bus.dp_out), 32'b0001);
    chk("single_segerr", 32'(bus.seg_err), 0);
    step();
    chk("single_hold_hex0", 32'(bus.hex0), 3);
    chk("single_fv", 32'(fv_cnt), 0);

    // Full frame 1,C,5,A
    fv_cnt = 0;
    hold(4'b0001, 8'h4F, 4);
    hold(4'b0010, 8'h31, 4);
    hold(4'b0100, 8'h24, 4);
    chk("frame_fv_early", 32'(fv_cnt), 0);
    hold(4'b1000, 8'h08, 4);
    chk("frame_fv", 32'(fv_cnt), 1);
    chk("frame_hex0", 32'(bus.hex0), 32'h1);
    chk("frame_hex1", 32'(bus.hex1), 32'hC);
    chk("frame_hex2", 32'(bus.hex2), 32'h5);
    chk("frame_hex3", 32'(bus.hex3), 32'hA);
    chk("frame_dp", 32'(bus.dp_out), 0);

    // Reset mid-dwell of digit 3 after digits 1,2 were seen
    hold(4'b0010, 8'h12, 4);
    hold(4'b0100, 8'h86, 4);
    chk("pre_rst_dp", 32'(bus.dp_out), 32'b0100);
    hold(4'b1000, 8'h4C, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_hex0", 32'(bus.hex0), 0);
    chk("async_rst_hex1", 32'(bus.hex1), 0);
    chk("async_rst_hex2", 32'(bus.hex2), 0);
    chk("async_rst_hex3", 32'(bus.hex3), 0);
    chk("async_rst_dp", 32'(bus.dp_out), 0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    fv_cnt = 0;
    hold(4'b1000, 8'h4C, 4);
    hold(4'b0001, 8'h81, 4);
    chk("rst_seen_cleared", 32'(fv_cnt), 0);
    hold(4'b0010, 8'h12, 4);
    hold(4'b0100, 8'h06, 4);
    chk("post_rst_fv", 32'(fv_cnt), 1);
    chk("post_rst_hex0", 32'(bus.hex0), 0);
    chk("post_rst_hex1", 32'(bus.hex1), 2);
    chk("post_rst_hex2", 32'(bus.hex2), 3);
    chk("post_rst_hex3", 32'(bus.hex3), 4);
    chk("post_rst_dp", 32'(bus.dp_out), 32'b0001);

    // Glitch: a one-cycle 1 then a held 2 -> hex1 never shows 1
    hold(4'b0010, 8'h01, 4);
    chk("glitch_pre_hex1", 32'(bus.hex1), 0);
    saw1 = 1'b0;
    hold(4'b0010, 8'h4F, 1);
    hold(4'b0010, 8'h12, 4);
    chk("glitch_hex1", 32'(bus.hex1), 2);
    chk("glitch_never1", 32'(saw1), 0);
    hold(4'b0010, 8'h06, 2);
    hold(4'b0010, 8'h12, 1);
    chk("short_dwell_hex1", 32'(bus.hex1), 2);
    hold(4'b0010, 8'h12, 3);

    // Bad pattern holds the digit and flags it; a good pattern clears the flag
    hold(4'b0100, 8'h00, 4);
    chk("bad_pre_hex2", 32'(bus.hex2), 8);
    hold(4'b0100, 8'h7F, 4);
    chk("bad_segerr", 32'(bus.seg_err), 32'b0100);
    chk("bad_hex2", 32'(bus.hex2), 8);
    hold(4'b0100, 8'h06, 4);
    chk("good_hex2", 32'(bus.hex2), 3);
    chk("good_segerr", 32'(bus.seg_err), 0);

    // Non-one-hot enable, then loss of scan
    oh_cnt = 0;
    hold(4'b0011, 8'h06, 4);
    chk("oh_pulse", 32'(oh_cnt), 1);
    chk("oh_hex0", 32'(bus.hex0), 0);
    chk("oh_hex1", 32'(bus.hex1), 2);
    chk("oh_hex2", 32'(bus.hex2), 3);
    chk("oh_hex3", 32'(bus.hex3), 4);
    chk("oh_lost_early", 32'(bus.scan_lost), 0);
    hold(4'b0011, 8'h06, 250);
    chk("lost_at_255", 32'(bus.scan_lost), 0);
    chk("oh_single", 32'(oh_cnt), 1);
    hold(4'b0011, 8'h06, 1);
    chk("lost_at_256", 32'(bus.scan_lost), 1);
    hold(4'b0001, 8'h4F, 2);
    chk("lost_before_cap", 32'(bus.scan_lost), 1);
    hold(4'b0001, 8'h4F, 1);
    chk("lost_cleared", 32'(bus.scan_lost), 0);
    chk("lost_cap_hex0", 32'(bus.hex0), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
